div_issue_queue: RTL



---
 rtl/div_issue_queue.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/div_issue_queue.sv
// div_issue_queue
// Issue/writeback controller in front of the stage-3 divide unit.
// Buffers up to DEPTH divide/remainder micro-ops and issues them one at a
// time to the unit with a one-cycle start pulse. It then waits for the unit
// to finish and formats the result, applying W-form sign extension and the
// divide-by-zero bypass. The result is presented as a tagged writeback.
//
// Ports
//   clk, rst (async, active-low), flush   : clock, reset, pipeline kill
//   in_valid/in_ready, in_op1/op2/select/tag : dispatch side
//   div_op1/op2/select, div_start          : operands and start to the unit
//   div_ready, div_result                  : completion from the unit
//   wb_valid/wb_ready, wb_tag, wb_data     : stage-3 result bus
module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_op1,
    input  logic [63:0]      in_op2,
    input  logic [2:0]       in_select,
    input  logic [TAG_W-1:0] in_tag,
    output logic [63:0]      div_op1,
    output logic [63:0]      div_op2,
    output logic [2:0]       div_select,
    output logic             div_start,
    input  logic             div_ready,
    input  logic [63:0]      div_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [63:0]      wb_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_REM   = 3'd2;
    localparam logic [2:0] OP_REMU  = 3'd3;
    localparam logic [2:0] OP_DIVW  = 3'd4;
    localparam logic [2:0] OP_DIVUW = 3'd5;
    localparam logic [2:0] OP_REMW  = 3'd6;
    localparam logic [2:0] OP_REMUW = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_BUSY    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WB      = 3'd4
    } state_e;

    function automatic logic sel_is_w(input logic [2:0] sel);
        logic w;
        case (sel)
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: w = 1'b1;
            default:                              w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic sel_is_rem(input logic [2:0] sel);
        logic r;
        case (sel)
            OP_REM, OP_REMU, OP_REMW, OP_REMUW: r = 1'b1;
            OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW: r = 1'b0;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // W ops only look at the low word of the divisor.
    function automatic logic divisor_zero(input logic [2:0] sel, input logic [63:0] op2);
        return sel_is_w(sel) ? (op2[31:0] == 32'd0) : (op2 == 64'd0);
    endfunction

    // Architectural result of a divide by zero: quotient is all ones, remainder is the dividend.
    function automatic logic [63:0] bypass_value(input logic [2:0] sel, input logic [63:0] op1);
        logic [63:0] v;
        if (!sel_is_rem(sel)) begin
            v = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (sel_is_w(sel)) begin
            v = sext32(op1[31:0]);
        end else begin
            v = op1;
        end
        return v;
    endfunction

    function automatic logic [63:0] format_result(input logic [2:0] sel, input logic [63:0] res);
        return sel_is_w(sel) ? sext32(res[31:0]) : res;
    endfunction

    // Queue storage and control
    logic [63:0]      fifo_op1_q [DEPTH];
    logic [63:0]      fifo_op2_q [DEPTH];
    logic [2:0]       fifo_sel_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_e           state_q, state_d;
    logic             discard_q, discard_d;
    logic [63:0]      iss_op1_q, iss_op1_d, iss_op2_q, iss_op2_d;
    logic [2:0]       iss_sel_q, iss_sel_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [63:0]      wb_data_q, wb_data_d;

    logic             in_ready_s, enq_s, pop_s, head_zero_s;
    logic             div_start_s, wb_valid_s;

    // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready_s  = (count_q != CNT_W'(DEPTH));
    assign enq_s       = in_valid && in_ready_s && !flush;
    assign pop_s       = (state_q == S_IDLE) && (count_q != CNT_W'(0)) && !flush;
    assign head_zero_s = divisor_zero(fifo_sel_q[rd_ptr_q], fifo_op2_q[rd_ptr_q]);

    // Queue entry storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op1_q[i] <= 64'd0;
                fifo_op2_q[i] <= 64'd0;
                fifo_sel_q[i] <= 3'd0;
                fifo_tag_q[i] <= '0;
            end
        end else if (enq_s) begin
            fifo_op1_q[wr_ptr_q] <= in_op1;
            fifo_op2_q[wr_ptr_q] <= in_op2;
            fifo_sel_q[wr_ptr_q] <= in_select;
            fifo_tag_q[wr_ptr_q] <= in_tag;
        end
    end

    // Pointer and occupancy next state; flush empties the queue and drops any enqueue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FSM next state; a flush during BUSY must still wait for the unit to finish
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (flush) begin
            case (state_q)
                S_BUSY: begin
                    if (div_ready) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = S_BUSY;
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_d = head_zero_s ? S_WB : S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: state_d = S_BUSY;
                S_BUSY: begin
                    if (div_ready) begin
                        state_d   = discard_q ? S_IDLE : S_CAPTURE;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = S_BUSY;
                    end
                end
                S_CAPTURE: state_d = S_WB;
                S_WB: begin
                    if (wb_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                end
            endcase
        end
    end

    // Issue and writeback register next state
    always_comb begin
        iss_op1_d = iss_op1_q;
        iss_op2_d = iss_op2_q;
        iss_sel_d = iss_sel_q;
        wb_tag_d  = wb_tag_q;
        wb_data_d = wb_data_q;
        if (pop_s) begin
            iss_op1_d = fifo_op1_q[rd_ptr_q];
            iss_op2_d = fifo_op2_q[rd_ptr_q];
            iss_sel_d = fifo_sel_q[rd_ptr_q];
            wb_tag_d  = fifo_tag_q[rd_ptr_q];
            if (head_zero_s) begin
                wb_data_d = bypass_value(fifo_sel_q[rd_ptr_q], fifo_op1_q[rd_ptr_q]);
            end else begin
                wb_data_d = wb_data_q;
            end
        end else if ((state_q == S_CAPTURE) && !flush) begin
            // The unit registered its result on the ready edge, so it is stable here.
            wb_data_d = format_result(iss_sel_q, div_result);
        end else begin
            wb_data_d = wb_data_q;
        end
    end

    // State, pointer and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            iss_op1_q <= 64'd0;
            iss_op2_q <= 64'd0;
            iss_sel_q <= 3'd0;
            wb_tag_q  <= '0;
            wb_data_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            iss_op1_q <= iss_op1_d;
            iss_op2_q <= iss_op2_d;
            iss_sel_q <= iss_sel_d;
            wb_tag_q  <= wb_tag_d;
            wb_data_q <= wb_data_d;
        end
    end

    // FSM output decode from the registered state
    always_comb begin
        div_start_s = 1'b0;
        wb_valid_s  = 1'b0;
        case (state_q)
            S_START: div_start_s = 1'b1;
            S_WB:    wb_valid_s  = 1'b1;
            default: begin
                div_start_s = 1'b0;
                wb_valid_s  = 1'b0;
            end
        endcase
    end

    assign in_ready   = in_ready_s;
    assign div_op1    = iss_op1_q;
    assign div_op2    = iss_op2_q;
    assign div_select = iss_sel_q;
    assign div_start  = div_start_s;
    assign wb_valid   = wb_valid_s;
    assign wb_tag     = wb_tag_q;
    assign wb_data    = wb_data_q;

endmodule
